// File: rtl/adc_packetizer.sv
// ADC byte-stream packetizer: buffers samples in a byte FIFO and emits fixed-size
// UDP payload packets (4-byte header + PAYLOAD_LEN bytes) separated by an idle gap.
module adc_packetizer #(
  parameter int unsigned PAYLOAD_LEN = 1024,
  parameter int unsigned FIFO_DEPTH  = 4096,
  parameter int unsigned IFG_CYCLES  = 16,
  parameter logic [15:0] MAGIC       = 16'hADC0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    din,
  input  logic                          din_valid,
  input  logic                          udp_tx_busy,
  output logic [7:0]                    udp_tx_data,
  output logic                          udp_tx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   seq_num,
  output logic                          overflow
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW   = AW + 1;
  localparam int unsigned CntMax = (PAYLOAD_LEN > IFG_CYCLES) ? PAYLOAD_LEN : IFG_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StHdr, StPayload, StGap} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     seq_q, seq_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;

  logic            start, last_pay, pop, push, drop;
  logic [7:0]      rd_data;

  assign start    = (level_q >= LvlW'(PAYLOAD_LEN)) && !udp_tx_busy;
  assign last_pay = (cnt_q == CntW'(PAYLOAD_LEN - 1));
  assign rd_data  = mem_q[rd_ptr_q];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: state_q/cnt_q name the byte slot currently on the output register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StHdr;
          cnt_d   = CntW'(1);
        end
      end
      StHdr: begin
        if (cnt_q == CntW'(3)) begin
          state_d = StPayload;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPayload: begin
        if (last_pay) begin
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == CntW'(IFG_CYCLES - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: the byte registered at the end of this cycle, plus FIFO pop and sequence bump
  always_comb begin
    tx_valid_d = 1'b0;
    tx_data_d  = 8'h00;
    pop        = 1'b0;
    seq_d      = seq_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          tx_valid_d = 1'b1;
          tx_data_d  = MAGIC[15:8];
        end
      end
      StHdr: begin
        tx_valid_d = 1'b1;
        case (cnt_q[1:0])
          2'd1:    tx_data_d = MAGIC[7:0];
          2'd2:    tx_data_d = seq_q[15:8];
          default: tx_data_d = seq_q[7:0];
        endcase
      end
      StPayload: begin
        tx_valid_d = 1'b1;
        tx_data_d  = rd_data;
        pop        = 1'b1;
        if (last_pay) seq_d = seq_q + 16'd1;
      end
      StGap: begin
        tx_valid_d = 1'b0;
      end
      default: begin
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // FIFO bookkeeping; a write at full is still accepted when a read frees a slot
  always_comb begin
    push       = din_valid && ((level_q != LvlW'(FIFO_DEPTH)) || pop);
    drop       = din_valid && (level_q == LvlW'(FIFO_DEPTH)) && !pop;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LvlW'(1);
    end
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      seq_q      <= 16'h0000;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      seq_q      <= seq_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign udp_tx_data  = tx_data_q;
  assign udp_tx_valid = tx_valid_q;
  assign fifo_level   = level_q;
  assign seq_num      = seq_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_adc_packetizer.sv
// Bench for adc_packetizer: directed vector table, multi-cycle scenarios and a
// randomized run, all checked against a queue-based packet model.
module tb_adc_packetizer;

  localparam int PL    = 8;
  localparam int DEPTH = 16;
  localparam int IFG   = 4;
  localparam logic [7:0] MAG_HI = 8'hAD;
  localparam logic [7:0] MAG_LO = 8'hC0;

  logic        clk;
  logic        rst_n;
  logic [7:0]  din;
  logic        din_valid;
  logic        udp_tx_busy;
  logic [7:0]  udp_tx_data;
  logic        udp_tx_valid;
  logic [4:0]  fifo_level;
  logic [15:0] seq_num;
  logic        overflow;

  adc_packetizer #(
    .PAYLOAD_LEN(PL),
    .FIFO_DEPTH (DEPTH),
    .IFG_CYCLES (IFG),
    .MAGIC      ({MAG_HI, MAG_LO})
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .udp_tx_busy (udp_tx_busy),
    .udp_tx_data (udp_tx_data),
    .udp_tx_valid(udp_tx_valid),
    .fifo_level  (fifo_level),
    .seq_num     (seq_num),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: byte FIFO plus a queue of pending output slots (256 = next FIFO byte)
  int          m_fifo[$];
  int          m_out[$];
  int          m_gap;
  logic [15:0] m_seq;
  logic        m_ovf;
  logic        m_valid;
  logic [7:0]  m_data;

  bit s_v[$];
  int s_d[$];
  int vb[$];
  int b_st[$];
  int b_ln[$];

  typedef struct {
    logic        r;
    logic [7:0]  d;
    logic        dv;
    logic        b;
    logic        ev;
    logic [7:0]  ed;
    int          el;
    logic [15:0] es;
    logic        eo;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [7:0] d, logic dv, logic b, logic ev,
                              logic [7:0] ed, int el, logic [15:0] es, logic eo);
    vec_t v;
    v.r = r; v.d = d; v.dv = dv; v.b = b;
    v.ev = ev; v.ed = ed; v.el = el; v.es = es; v.eo = eo;
    return v;
  endfunction

  task automatic model_step(input logic r, input logic [7:0] d, input logic dv, input logic b);
    int pre;
    bit rd;
    int v;
    if (!r) begin
      m_fifo.delete(); m_out.delete();
      m_gap = 0; m_seq = 16'h0; m_ovf = 1'b0; m_valid = 1'b0; m_data = 8'h00;
      return;
    end
    pre = m_fifo.size();
    rd = 1'b0;
    m_valid = 1'b0;
    m_data = 8'h00;
    if (m_out.size() > 0) begin
      v = m_out.pop_front();
      m_valid = 1'b1;
      if (v == 256) begin
        m_data = 8'(m_fifo.pop_front());
        rd = 1'b1;
        if (m_out.size() == 0) begin
          m_seq = m_seq + 16'd1;
          m_gap = IFG;
        end
      end else begin
        m_data = 8'(v);
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (pre >= PL && !b) begin
      m_valid = 1'b1;
      m_data = MAG_HI;
      m_out.push_back(int'(MAG_LO));
      m_out.push_back(int'(m_seq[15:8]));
      m_out.push_back(int'(m_seq[7:0]));
      repeat (PL) m_out.push_back(256);
    end
    if (dv) begin
      if (pre < DEPTH || rd) m_fifo.push_back(int'(d));
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_model();
    n_vec++;
    if (udp_tx_valid !== m_valid || udp_tx_data !== m_data || int'(fifo_level) != m_fifo.size()
        || seq_num !== m_seq || overflow !== m_ovf) begin
      n_err++;
      $display("FAIL model @%0t: got v=%0b d=%02h lvl=%0d seq=%04h ovf=%0b, want v=%0b d=%02h lvl=%0d seq=%04h ovf=%0b",
               $time, udp_tx_valid, udp_tx_data, fifo_level, seq_num, overflow,
               m_valid, m_data, m_fifo.size(), m_seq, m_ovf);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input logic r, input logic [7:0] d, input logic dv, input logic b);
    rst_n = r; din = d; din_valid = dv; udp_tx_busy = b;
    @(posedge clk);
    model_step(r, d, dv, b);
    #1;
    check_model();
    s_v.push_back(udp_tx_valid);
    s_d.push_back(int'(udp_tx_data));
  endtask

  task automatic clear_stream();
    s_v.delete();
    s_d.delete();
  endtask

  task automatic collect_vb();
    vb.delete();
    foreach (s_v[i]) if (s_v[i]) vb.push_back(s_d[i]);
  endtask

  task automatic cmp_stream(input string name, input int exp[$]);
    int mism;
    collect_vb();
    chk({name, "_len"}, vb.size(), exp.size());
    mism = 0;
    for (int i = 0; i < vb.size() && i < exp.size(); i++) if (vb[i] != exp[i]) mism++;
    chk({name, "_bytes"}, mism, 0);
  endtask

  task automatic find_bursts();
    int i;
    b_st.delete();
    b_ln.delete();
    i = 0;
    while (i < s_v.size()) begin
      if (s_v[i]) begin
        b_st.push_back(i);
        b_ln.push_back(0);
        while (i < s_v.size() && s_v[i]) begin
          b_ln[b_ln.size()-1]++;
          i++;
        end
      end else begin
        i++;
      end
    end
  endtask

  initial begin
    logic [7:0] hdr [4];
    int exp_q[$];
    int nv;
    int written;
    int mism;
    bit w;
    logic busy_r;
    logic rr;
    logic dvr;

    n_vec = 0; n_err = 0;
    rst_n = 1'b0; din = 8'h00; din_valid = 1'b0; udp_tx_busy = 1'b0;
    m_fifo.delete(); m_out.delete();
    m_gap = 0; m_seq = 16'h0; m_ovf = 1'b0; m_valid = 1'b0; m_data = 8'h00;
    hdr[0] = 8'hAD; hdr[1] = 8'hC0; hdr[2] = 8'h00; hdr[3] = 8'h00;

    // Reset, then one packet of 0x01..0x08
    tbl.push_back(mk(1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 0, 16'h0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h66, 1'b1, 1'b0, 1'b0, 8'h00, 0, 16'h0, 1'b0));
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, 8'h00, i, 16'h0, 1'b0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, hdr[k], 8, 16'h0, 1'b0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'(k + 1), 7 - k,
                       (k == 7) ? 16'h1 : 16'h0, 1'b0));
    repeat (5) tbl.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 16'h1, 1'b0));

    foreach (tbl[i]) begin
      tick(tbl[i].r, tbl[i].d, tbl[i].dv, tbl[i].b);
      n_vec++;
      if (udp_tx_valid !== tbl[i].ev || udp_tx_data !== tbl[i].ed
          || int'(fifo_level) != tbl[i].el || seq_num !== tbl[i].es || overflow !== tbl[i].eo) begin
        n_err++;
        $display("FAIL table row %0d: got v=%0b d=%02h lvl=%0d seq=%04h ovf=%0b, want v=%0b d=%02h lvl=%0d seq=%04h ovf=%0b",
                 i, udp_tx_valid, udp_tx_data, fifo_level, seq_num, overflow,
                 tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].es, tbl[i].eo);
      end
    end

    // Busy holds off a ready packet; header follows one cycle after busy drops
    for (int i = 0; i < 8; i++) tick(1'b1, 8'h20 + 8'(i), 1'b1, 1'b1);
    nv = 0;
    repeat (20) begin
      tick(1'b1, 8'h00, 1'b0, 1'b1);
      if (udp_tx_valid) nv++;
    end
    chk("busy_hold_valid", nv, 0);
    tick(1'b1, 8'h00, 1'b0, 1'b0);
    chk("busy_release_valid", int'(udp_tx_valid), 1);
    chk("busy_release_data", int'(udp_tx_data), 'hAD);
    repeat (20) tick(1'b1, 8'h00, 1'b0, 1'b0);

    // 40 bytes streamed so packets run back-to-back
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    clear_stream();
    written = 0;
    for (int n = 1; n <= 100; n++) begin
      w = (n <= 16) || (n >= 18 && (n % 2) == 0 && written < 40);
      if (w) begin
        written++;
        tick(1'b1, 8'(written), 1'b1, 1'b0);
      end else begin
        tick(1'b1, 8'h00, 1'b0, 1'b0);
      end
    end
    find_bursts();
    chk("b2b_burst_count", b_st.size(), 5);
    for (int k = 0; k < b_st.size(); k++) begin
      chk("b2b_burst_len", b_ln[k], 12);
      if (k > 0) chk("b2b_gap", b_st[k] - (b_st[k-1] + b_ln[k-1]), 4);
      if (b_ln[k] == 12) begin
        chk("b2b_magic_hi", s_d[b_st[k]], 'hAD);
        chk("b2b_magic_lo", s_d[b_st[k] + 1], 'hC0);
        chk("b2b_seq", s_d[b_st[k] + 2] * 256 + s_d[b_st[k] + 3], k);
        mism = 0;
        for (int j = 0; j < PL; j++) if (s_d[b_st[k] + 4 + j] != 8 * k + j + 1) mism++;
        chk("b2b_payload", mism, 0);
      end
    end
    chk("b2b_overflow", int'(overflow), 0);

    // Overflow while busy: only the first 16 bytes survive, in order
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b1, 8'h40 + 8'(i), 1'b1, 1'b1);
    chk("ovf_level", int'(fifo_level), 16);
    chk("ovf_flag", int'(overflow), 1);
    clear_stream();
    repeat (40) tick(1'b1, 8'h00, 1'b0, 1'b0);
    exp_q.delete();
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back('hAD); exp_q.push_back('hC0); exp_q.push_back(0); exp_q.push_back(p);
      for (int j = 0; j < PL; j++) exp_q.push_back('h40 + 8 * p + j);
    end
    cmp_stream("ovf_stream", exp_q);
    chk("ovf_sticky", int'(overflow), 1);

    // Sequence wrap from 0xFFFF
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    force dut.seq_q = 16'hFFFF;
    m_seq = 16'hFFFF;
    tick(1'b1, 8'h00, 1'b0, 1'b0);
    release dut.seq_q;
    clear_stream();
    for (int i = 0; i < 16; i++) tick(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
    repeat (30) tick(1'b1, 8'h00, 1'b0, 1'b0);
    exp_q.delete();
    exp_q.push_back('hAD); exp_q.push_back('hC0); exp_q.push_back('hFF); exp_q.push_back('hFF);
    for (int j = 0; j < PL; j++) exp_q.push_back('h10 + j);
    exp_q.push_back('hAD); exp_q.push_back('hC0); exp_q.push_back(0); exp_q.push_back(0);
    for (int j = 0; j < PL; j++) exp_q.push_back('h18 + j);
    cmp_stream("wrap_stream", exp_q);
    chk("wrap_seq_after", int'(seq_num), 1);

    // Reset on the 6th payload cycle discards everything
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0);
    chk("midrst_pre_valid", int'(udp_tx_valid), 1);
    chk("midrst_pre_data", int'(udp_tx_data), 'h85);
    tick(1'b0, 8'h77, 1'b1, 1'b0);
    chk("midrst_valid", int'(udp_tx_valid), 0);
    chk("midrst_data", int'(udp_tx_data), 0);
    chk("midrst_level", int'(fifo_level), 0);
    chk("midrst_seq", int'(seq_num), 0);
    clear_stream();
    for (int i = 0; i < 8; i++) tick(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0);
    repeat (20) tick(1'b1, 8'h00, 1'b0, 1'b0);
    exp_q.delete();
    exp_q.push_back('hAD); exp_q.push_back('hC0); exp_q.push_back(0); exp_q.push_back(0);
    for (int j = 0; j < PL; j++) exp_q.push_back('hC0 + j);
    cmp_stream("midrst_stream", exp_q);

    // Randomized traffic against the model
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    busy_r = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      rr  = ($urandom % 600) != 0;
      dvr = ($urandom % 4) != 0;
      if (($urandom % 20) == 0) busy_r = ~busy_r;
      tick(rr, 8'($urandom), dvr, busy_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
